ltl_monitor_cluster_agg: RTL and testbench

Parametrised aggregation and reporting stage for one runtime-monitor cluster. It sits between an automata stage (raw per-property report taps) and the SoC monitor interface. It performs these functions:
- OR-reduces each property's report taps into a live flag.
- Adds an enable mask.
- Keeps per-property sticky flags and saturating hit counters.
- Captures the first violation (property id, timestamp, symbol vector).
- Raises an interrupt with an acknowledge handshake.

---
 rtl/ltl_monitor_cluster_agg.sv | 153 +++++++++++++++
 tb/tb_ltl_monitor_cluster_agg.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ltl_monitor_cluster_agg.sv
// ltl_monitor_cluster_agg
//   Aggregation and reporting stage for one runtime-monitor cluster. It
//   OR-reduces the per-property report taps, qualifies them with run and an
//   enable mask, and then does four things with the qualified hits:
//   - keeps sticky flags;
//   - keeps saturating hit counters, one per property;
//   - captures the first violation;
//   - drives a level interrupt with an acknowledge.
//
// Ports
//   clk, reset     clock, asynchronous active-high reset
//   run            qualifies taps and advances the free-running timestamp
//   symbols        symbol vector, sampled on the first violation
//   taps           raw taps, property p at [p*NUM_TAPS +: NUM_TAPS]
//   prop_en        per-property enable mask
//   clear          synchronous clear of sticky/counters/capture/irq
//   irq_ack        interrupt acknowledge
//   sel_prop       hit-counter readback index
//   prop_live      unqualified per-property OR of taps (combinational)
//   prop_sticky    sticky violation flags
//   hit_count      counter of sel_prop, one cycle behind the counter
//   first_valid/first_id/first_ts/first_sym   first-violation capture
//   irq            level interrupt
module ltl_monitor_cluster_agg #(
  parameter int SYM_W     = 8,
  parameter int NUM_PROPS = 11,
  parameter int NUM_TAPS  = 4,
  parameter int TS_W      = 16,
  parameter int HC_W      = 8,
  parameter int ID_W      = (NUM_PROPS > 1) ? $clog2(NUM_PROPS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic [SYM_W-1:0]              symbols,
  input  logic [NUM_PROPS*NUM_TAPS-1:0] taps,
  input  logic [NUM_PROPS-1:0]          prop_en,
  input  logic                          clear,
  input  logic                          irq_ack,
  input  logic [ID_W-1:0]               sel_prop,
  output logic [NUM_PROPS-1:0]          prop_live,
  output logic [NUM_PROPS-1:0]          prop_sticky,
  output logic [HC_W-1:0]               hit_count,
  output logic                          first_valid,
  output logic [ID_W-1:0]               first_id,
  output logic [TS_W-1:0]               first_ts,
  output logic [SYM_W-1:0]              first_sym,
  output logic                          irq
);

  localparam logic [HC_W-1:0] HC_MAX = {HC_W{1'b1}};

  logic [NUM_PROPS-1:0] qhit;
  logic [TS_W-1:0]      ts_reg;
  logic [HC_W-1:0]      cnt_reg [NUM_PROPS];
  logic [HC_W-1:0]      sel_cnt;
  logic [ID_W-1:0]      low_id;
  logic                 any_qhit;
  logic                 new_sticky;

  assign qhit       = prop_live & prop_en & {NUM_PROPS{run}};
  assign any_qhit   = |qhit;
  // A hit on a property that is not yet sticky is what raises the interrupt.
  assign new_sticky = |(qhit & ~prop_sticky);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PROPS; gi++) begin : g_prop
      assign prop_live[gi] = |taps[gi*NUM_TAPS +: NUM_TAPS];

      // Sticky flag: a same-cycle hit wins over clear.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          prop_sticky[gi] <= 1'b0;
        end else if (clear) begin
          prop_sticky[gi] <= qhit[gi];
        end else if (qhit[gi]) begin
          prop_sticky[gi] <= 1'b1;
        end
      end

      // Saturating hit counter; clear with a same-cycle hit restarts at 1.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg[gi] <= '0;
        end else if (clear) begin
          cnt_reg[gi] <= qhit[gi] ? HC_W'(1) : '0;
        end else if (qhit[gi] && (cnt_reg[gi] != HC_MAX)) begin
          cnt_reg[gi] <= cnt_reg[gi] + HC_W'(1);
        end
      end
    end
  endgenerate

  // Lowest-index qualified hit: scan downwards so the lowest index wins.
  always_comb begin
    low_id = '0;
    for (int p = NUM_PROPS - 1; p >= 0; p--) begin
      if (qhit[p]) low_id = ID_W'(p);
    end
  end

  // Readback mux; indices beyond the property count read as zero.
  always_comb begin
    sel_cnt = '0;
    for (int p = 0; p < NUM_PROPS; p++) begin
      if (sel_prop == ID_W'(p)) sel_cnt = cnt_reg[p];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_reg    <= '0;
      hit_count <= '0;
    end else begin
      if (run) ts_reg <= ts_reg + TS_W'(1);
      hit_count <= sel_cnt;
    end
  end

  // First-violation capture. A clear re-arms the capture in the same cycle,
  // so an event coinciding with clear is captured rather than lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_valid <= 1'b0;
      first_id    <= '0;
      first_ts    <= '0;
      first_sym   <= '0;
    end else if ((!first_valid || clear) && any_qhit) begin
      first_valid <= 1'b1;
      first_id    <= low_id;
      first_ts    <= ts_reg;
      first_sym   <= symbols;
    end else if (clear) begin
      first_valid <= 1'b0;
      first_id    <= '0;
      first_ts    <= '0;
      first_sym   <= '0;
    end
  end

  // Interrupt: a new-sticky event has priority over both clear and ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (new_sticky) begin
      irq <= 1'b1;
    end else if (clear || irq_ack) begin
      irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ltl_monitor_cluster_agg.sv
// Self-checking bench for ltl_monitor_cluster_agg with default parameters.
// A behavioural model computes the expected outputs for each driven cycle,
// pushes them to a scoreboard queue, and they are popped and compared after
// the clock edge that produces them.
module tb_ltl_monitor_cluster_agg;

  localparam int NP = 11;
  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [7:0]    symbols;
  logic [NP*NT-1:0] taps;
  logic [NP-1:0] prop_en;
  logic          clear;
  logic          irq_ack;
  logic [3:0]    sel_prop;
  logic [NP-1:0] prop_live;
  logic [NP-1:0] prop_sticky;
  logic [7:0]    hit_count;
  logic          first_valid;
  logic [3:0]    first_id;
  logic [15:0]   first_ts;
  logic [7:0]    first_sym;
  logic          irq;

  ltl_monitor_cluster_agg dut (
    .clk(clk), .reset(reset), .run(run), .symbols(symbols), .taps(taps),
    .prop_en(prop_en), .clear(clear), .irq_ack(irq_ack), .sel_prop(sel_prop),
    .prop_live(prop_live), .prop_sticky(prop_sticky), .hit_count(hit_count),
    .first_valid(first_valid), .first_id(first_id), .first_ts(first_ts),
    .first_sym(first_sym), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0] sticky;
    logic          irq;
    logic          fv;
    logic [3:0]    fid;
    logic [15:0]   fts;
    logic [7:0]    fsym;
    logic [7:0]    hc;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [15:0]   m_ts;
  logic [NP-1:0] m_sticky;
  int            m_cnt [NP];
  logic          m_irq, m_fv;
  logic [3:0]    m_fid;
  logic [15:0]   m_fts;
  logic [7:0]    m_fsym;
  logic [7:0]    m_hc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ts = '0; m_sticky = '0; m_irq = 1'b0; m_fv = 1'b0;
    m_fid = '0; m_fts = '0; m_fsym = '0; m_hc = '0;
    for (int p = 0; p < NP; p++) m_cnt[p] = 0;
  endtask

  function automatic logic [NP-1:0] live_of(input logic [NP*NT-1:0] t);
    logic [NP-1:0] l;
    for (int p = 0; p < NP; p++) l[p] = |t[p*NT +: NT];
    return l;
  endfunction

  // Called at a negedge with the inputs already driven: one clock cycle.
  task automatic cycle();
    exp_t e, o;
    logic [NP-1:0] q;
    logic new_st, any;
    int lo;
    #1;
    chk("prop_live", prop_live, live_of(taps));
    q = live_of(taps) & prop_en & {NP{run}};
    any = |q;
    new_st = |(q & ~m_sticky);
    lo = 0;
    for (int p = NP - 1; p >= 0; p--) if (q[p]) lo = p;
    m_hc = (sel_prop < NP) ? 8'(m_cnt[sel_prop]) : 8'd0;
    if (new_st) m_irq = 1'b1;
    else if (clear || irq_ack) m_irq = 1'b0;
    m_sticky = clear ? q : (m_sticky | q);
    for (int p = 0; p < NP; p++) begin
      if (clear) m_cnt[p] = q[p] ? 1 : 0;
      else if (q[p] && m_cnt[p] < 255) m_cnt[p]++;
    end
    if ((!m_fv || clear) && any) begin
      m_fv = 1'b1; m_fid = 4'(lo); m_fts = m_ts; m_fsym = symbols;
    end else if (clear) begin
      m_fv = 1'b0; m_fid = '0; m_fts = '0; m_fsym = '0;
    end
    if (run) m_ts = m_ts + 16'd1;
    e.sticky = m_sticky; e.irq = m_irq; e.fv = m_fv; e.fid = m_fid;
    e.fts = m_fts; e.fsym = m_fsym; e.hc = m_hc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    chk("prop_sticky", prop_sticky, o.sticky);
    chk("irq", irq, o.irq);
    chk("first_valid", first_valid, o.fv);
    chk("first_id", first_id, o.fid);
    chk("first_ts", first_ts, o.fts);
    chk("first_sym", first_sym, o.fsym);
    chk("hit_count", hit_count, o.hc);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    run = 1'b1; symbols = '0; taps = '0; prop_en = '1;
    clear = 1'b0; irq_ack = 1'b0; sel_prop = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sticky"}, prop_sticky, 0);
    chk({tag, "_hc"}, hit_count, 0);
    chk({tag, "_fv"}, first_valid, 0);
    chk({tag, "_fid"}, first_id, 0);
    chk({tag, "_fts"}, first_ts, 0);
    chk({tag, "_fsym"}, first_sym, 0);
    chk({tag, "_irq"}, irq, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    model_reset();
    sb_q.delete();
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    run = 1'b0;
    do_reset();

    // 10 idle run cycles, then a hit on prop 1 shows the timestamp was 10.
    idle_inputs();
    repeat (10) cycle();
    check_all_zero("idle10");
    taps[1*NT] = 1'b1; symbols = 8'h3C;
    cycle();
    taps = '0;
    chk("ts10_first_ts", first_ts, 10);
    chk("ts10_first_id", first_id, 1);

    // Fresh start: 5 idle cycles, prop 3 tap 2 with symbols 0xA5.
    idle_inputs();
    do_reset();
    repeat (5) cycle();
    taps[3*NT+2] = 1'b1; symbols = 8'hA5;
    cycle();
    taps = '0; symbols = '0;
    chk("p3_sticky", prop_sticky, 11'h008);
    chk("p3_irq", irq, 1);
    chk("p3_fid", first_id, 3);
    chk("p3_fts", first_ts, 5);
    chk("p3_fsym", first_sym, 8'hA5);

    // Clear, then props 7 and 2 together: lowest index captured.
    clear = 1'b1; irq_ack = 1'b1;
    cycle();
    clear = 1'b0; irq_ack = 1'b0;
    taps[7*NT+1] = 1'b1; taps[2*NT+3] = 1'b1;
    cycle();
    taps = '0;
    chk("p72_fid", first_id, 2);
    chk("p72_sticky", prop_sticky, 11'h084);
    chk("p72_irq", irq, 1);
    irq_ack = 1'b1;
    cycle();
    irq_ack = 1'b0;
    taps[2*NT] = 1'b1;
    cycle();
    taps = '0;
    chk("p2_rehit_irq", irq, 0);

    // Prop 0 held for 300 cycles: counter saturates at 255.
    sel_prop = 4'd0;
    taps[0] = 1'b1;
    repeat (300) cycle();
    taps = '0;
    cycle();
    chk("sat_hc", hit_count, 255);
    sel_prop = 4'd11;
    cycle();
    chk("sel11_hc", hit_count, 0);

    // Prop 4 disabled, then run low: live but nothing recorded.
    sel_prop = 4'd4;
    taps[4*NT+1] = 1'b1; prop_en = ~(11'(1) << 4);
    cycle();
    chk("en0_live4", prop_live[4], 1);
    chk("en0_sticky4", prop_sticky[4], 0);
    prop_en = '1; run = 1'b0;
    cycle();
    chk("run0_live4", prop_live[4], 1);
    chk("run0_sticky4", prop_sticky[4], 0);
    cycle();
    chk("run0_hc4", hit_count, 0);
    taps = '0; run = 1'b1;

    // Clear together with a prop 5 hit.
    clear = 1'b1; taps[5*NT+2] = 1'b1;
    cycle();
    clear = 1'b0; taps = '0; run = 1'b0; sel_prop = 4'd5;
    chk("clr5_sticky", prop_sticky, 11'h020);
    chk("clr5_fid", first_id, 5);
    chk("clr5_irq", irq, 1);
    cycle();
    chk("clr5_hc", hit_count, 1);

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      run = ($urandom_range(0, 3) != 0);
      symbols = 8'($urandom);
      taps = '0;
      if ($urandom_range(0, 2) == 0) taps[$urandom_range(0, NP*NT-1)] = 1'b1;
      if ($urandom_range(0, 5) == 0) taps[$urandom_range(0, NP*NT-1)] = 1'b1;
      prop_en = ($urandom_range(0, 3) == 0) ? 11'($urandom) : '1;
      clear = ($urandom_range(0, 15) == 0);
      irq_ack = ($urandom_range(0, 3) == 0);
      sel_prop = 4'($urandom_range(0, 15));
      cycle();
    end

    // Asynchronous reset mid-run, asserted between clock edges.
    idle_inputs();
    taps[6*NT] = 1'b1;
    cycle();
    #2 reset = 1'b1;
    #1 check_all_zero("async");
    model_reset();
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    taps = '0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
